axis_byte_packer: RTL

Width up-converter that sits directly upstream of the skid buffer in the streaming datapath. It accepts narrow AXI-Stream beats (default 8-bit pixels/bytes) and packs N = C_M00_AXIS_TDATA_WIDTH / C_S00_AXIS_TDATA_WIDTH consecutive beats into one wide word. Each wide word carries a per-byte tstrb. An input tlast closes the current word early, leaving it partially filled, and is forwarded on the output. The output is fully registered, so the downstream skid buffer sees registered tvalid/tdata/tstrb/tlast.

---
 rtl/axis_byte_packer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/axis_byte_packer.sv
// axis_byte_packer: AXI-Stream width up-converter.
// Packs N = C_M00_AXIS_TDATA_WIDTH / C_S00_AXIS_TDATA_WIDTH narrow beats into one
// wide word, first beat in the LSB lane. An input tlast closes the word early and
// is forwarded. Every output, including s00_axis_tready, is driven from a flop.
//
// Ports:
//   s00_axis_aclk    in   sole clock, rising edge
//   s00_axis_areset  in   synchronous active-high reset
//   s00_axis_tvalid  in   input beat valid
//   s00_axis_tdata   in   input beat [C_S00_AXIS_TDATA_WIDTH]
//   s00_axis_tlast   in   last beat of packet
//   s00_axis_tready  out  beat can be accepted (registered)
//   m00_axis_tready  in   downstream ready
//   m00_axis_tvalid  out  packed word valid (registered)
//   m00_axis_tdata   out  packed word [C_M00_AXIS_TDATA_WIDTH]
//   m00_axis_tstrb   out  byte-valid mask [C_M00_AXIS_TDATA_WIDTH/8]
//   m00_axis_tlast   out  word ends a packet
module axis_byte_packer #(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 8,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast
);

  localparam int unsigned S_W    = C_S00_AXIS_TDATA_WIDTH;
  localparam int unsigned M_W    = C_M00_AXIS_TDATA_WIDTH;
  localparam int unsigned N_LANE = M_W / S_W;
  localparam int unsigned LANE_B = S_W / 8;
  localparam int unsigned STRB_W = M_W / 8;
  localparam int unsigned IDX_W  = (N_LANE > 1) ? $clog2(N_LANE) : 1;

  typedef enum logic {
    FILLING = 1'b0,
    HELD    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [M_W-1:0]      acc_data_q, acc_data_d;
  logic [STRB_W-1:0]   acc_strb_q, acc_strb_d;
  logic                acc_last_q, acc_last_d;
  logic                s_tready_q, s_tready_d;
  logic                m_valid_q, m_valid_d;
  logic [M_W-1:0]      m_data_q, m_data_d;
  logic [STRB_W-1:0]   m_strb_q, m_strb_d;
  logic                m_last_q, m_last_d;

  logic                accept;
  logic                completing;
  logic                out_free;
  logic [M_W-1:0]      merged_data;
  logic [STRB_W-1:0]   merged_strb;

  assign accept     = s00_axis_tvalid && s_tready_q;
  assign completing = accept && ((idx_q == IDX_W'(N_LANE - 1)) || s00_axis_tlast);
  assign out_free   = !m_valid_q || m00_axis_tready;

  // Accumulator with the incoming beat dropped into lane idx; lanes above idx stay zero.
  always_comb begin
    merged_data = acc_data_q;
    merged_strb = acc_strb_q;
    for (int unsigned k = 0; k < N_LANE; k++) begin
      if (idx_q == IDX_W'(k)) begin
        merged_data[k*S_W +: S_W]       = s00_axis_tdata;
        merged_strb[k*LANE_B +: LANE_B] = '1;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_data_d = acc_data_q;
    acc_strb_d = acc_strb_q;
    acc_last_d = acc_last_q;
    m_valid_d  = m_valid_q && !m00_axis_tready;
    m_data_d   = m_data_q;
    m_strb_d   = m_strb_q;
    m_last_d   = m_last_q;

    case (state_q)
      FILLING: begin
        if (accept) begin
          if (completing && out_free) begin
            // Bypass the accumulator so word boundaries cost no bubble.
            m_valid_d  = 1'b1;
            m_data_d   = merged_data;
            m_strb_d   = merged_strb;
            m_last_d   = s00_axis_tlast;
            acc_data_d = '0;
            acc_strb_d = '0;
            acc_last_d = 1'b0;
            idx_d      = '0;
          end else if (completing) begin
            acc_data_d = merged_data;
            acc_strb_d = merged_strb;
            acc_last_d = s00_axis_tlast;
            state_d    = HELD;
          end else begin
            acc_data_d = merged_data;
            acc_strb_d = merged_strb;
            idx_d      = idx_q + IDX_W'(1);
          end
        end
      end
      HELD: begin
        if (out_free) begin
          m_valid_d  = 1'b1;
          m_data_d   = acc_data_q;
          m_strb_d   = acc_strb_q;
          m_last_d   = acc_last_q;
          acc_data_d = '0;
          acc_strb_d = '0;
          acc_last_d = 1'b0;
          idx_d      = '0;
          state_d    = FILLING;
        end
      end
      default: state_d = FILLING;
    endcase

    // tready is a flop reflecting the upcoming state, never a path from m00_axis_tready.
    s_tready_d = (state_d == FILLING);
  end

  // State and datapath registers.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q    <= FILLING;
      idx_q      <= '0;
      acc_data_q <= '0;
      acc_strb_q <= '0;
      acc_last_q <= 1'b0;
      s_tready_q <= 1'b1;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_strb_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_data_q <= acc_data_d;
      acc_strb_q <= acc_strb_d;
      acc_last_q <= acc_last_d;
      s_tready_q <= s_tready_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_strb_q   <= m_strb_d;
      m_last_q   <= m_last_d;
    end
  end

  assign s00_axis_tready = s_tready_q;
  assign m00_axis_tvalid = m_valid_q;
  assign m00_axis_tdata  = m_data_q;
  assign m00_axis_tstrb  = m_strb_q;
  assign m00_axis_tlast  = m_last_q;

endmodule
